// File: rtl/fp_div_pkg.sv
// Shared types and default sizing for the FP divide datapath.
package fp_div_pkg;

  localparam int MANT_W        = 28;
  localparam int DIV_FRAC_BITS = 28;
  localparam int DIV_QW        = MANT_W + DIV_FRAC_BITS;
  localparam int DIV_CNT_W     = $clog2(DIV_QW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, then compare and subtract the divisor.
module div_restore_step #(
  parameter int WIDTH = 28
) (
  input  logic [WIDTH:0]   pr,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_pr,
  output logic             q_bit
);

  logic [WIDTH+1:0] t;

  // pr < divisor always holds, so pr[WIDTH] is zero and the extra top bit of t never changes the result.
  always_comb begin
    t = {pr, in_bit};
    if (t >= {2'b00, divisor}) begin
      next_pr = t[WIDTH:0] - {1'b0, divisor};
      q_bit   = 1'b1;
    end else begin
      next_pr = t[WIDTH:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/mantissa_divider.sv
// Iterative restoring mantissa divider, one quotient bit per clock.
// Define MANTISSA_DIV_STICKY_EN to register sticky = |remainder; otherwise sticky is tied low.
module mantissa_divider
  import fp_div_pkg::*;
#(
  parameter int WIDTH     = MANT_W,
  parameter int FRAC_BITS = DIV_FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [WIDTH-1:0]               dividend,
  input  logic [WIDTH-1:0]               divisor,
  output logic                           busy,
  output logic                           done,
  output logic [WIDTH+FRAC_BITS-1:0]     quotient,
  output logic [WIDTH-1:0]               remainder,
  output logic                           sticky,
  output logic                           div_by_zero
);

  localparam int QW    = WIDTH + FRAC_BITS;
  localparam int CNT_W = (QW == DIV_QW) ? DIV_CNT_W : $clog2(QW);

  div_state_t        state;
  logic [QW-1:0]     shreg;
  logic [WIDTH:0]    pr;
  logic [QW-1:0]     q;
  logic [WIDTH-1:0]  dvsr;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH:0]    step_pr;
  logic              step_q;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr),
    .in_bit  (shreg[QW-1]),
    .divisor (dvsr),
    .next_pr (step_pr),
    .q_bit   (step_q)
  );

`ifndef MANTISSA_DIV_STICKY_EN
  assign sticky = 1'b0;
`endif

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= {QW{1'b0}};
      pr          <= {(WIDTH+1){1'b0}};
      q           <= {QW{1'b0}};
      dvsr        <= {WIDTH{1'b0}};
      cnt         <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {QW{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
`ifdef MANTISSA_DIV_STICKY_EN
      sticky      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == {WIDTH{1'b0}}) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= {QW{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
`ifdef MANTISSA_DIV_STICKY_EN
              sticky      <= (dividend != {WIDTH{1'b0}});
`endif
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              shreg <= {dividend, {FRAC_BITS{1'b0}}};
              pr    <= {(WIDTH+1){1'b0}};
              q     <= {QW{1'b0}};
              dvsr  <= divisor;
              cnt   <= CNT_W'(QW - 1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          pr    <= step_pr;
          q     <= {q[QW-2:0], step_q};
          shreg <= {shreg[QW-2:0], 1'b0};
          if (cnt == {CNT_W{1'b0}}) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= {q[QW-2:0], step_q};
            remainder   <= step_pr[WIDTH-1:0];
            div_by_zero <= 1'b0;
`ifdef MANTISSA_DIV_STICKY_EN
            sticky      <= |step_pr[WIDTH-1:0];
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_divider.sv
// Self-checking bench for mantissa_divider against an arithmetic reference model.
module tb_mantissa_divider;

  localparam int W  = 28;
  localparam int F  = 28;
  localparam int QW = W + F;
  localparam int LAT = QW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy;
  logic          done;
  logic [QW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          sticky;
  logic          div_by_zero;

  int tests_run = 0;
  int tests_failed = 0;

  mantissa_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .sticky      (sticky),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic exp_sticky(input logic [W-1:0] rem);
`ifdef MANTISSA_DIV_STICKY_EN
    return (rem != '0);
`else
    return 1'b0;
`endif
  endfunction

  // Starts one operation and waits (bounded) for done; optionally pulses start again mid-run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch_at,
                        output int lat, output bit first_busy, output bit busy_seen);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    lat        = 1;
    first_busy = (busy === 1'b1);
    busy_seen  = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      busy_seen = busy_seen | (busy === 1'b1);
      if (lat == glitch_at) begin
        start    = 1'b1;
        dividend = 28'd100;
        divisor  = 28'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tests_run++;
    if ({busy, done, quotient, remainder, sticky, div_by_zero} !== '0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b q=%h r=%h sticky=%b dbz=%b, required all 0",
               busy, done, quotient, remainder, sticky, div_by_zero);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_quotient();
    int lat; bit fb, bs;
    run_op(28'd3, 28'd2, -1, lat, fb, bs);
    tests_run++;
    if (lat !== LAT || fb !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL quot_timing: lat=%0d first_busy=%b busy_at_done=%b, required %0d 1 0", lat, fb, busy, LAT);
    end
    tests_run++;
    if (quotient !== 56'h1800_0000 || remainder !== '0 || sticky !== 1'b0 || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL quot_3_2: q=%h r=%h s=%b dbz=%b, required q=1800_0000 r=0 s=0 dbz=0",
               quotient, remainder, sticky, div_by_zero);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_sticky();
    int lat; bit fb, bs;
    run_op(28'd1, 28'd3, -1, lat, fb, bs);
    tests_run++;
    if (lat !== LAT || quotient !== 56'h555_5555 || remainder !== 28'd1 || sticky !== exp_sticky(28'd1)) begin
      tests_failed++;
      $display("FAIL sticky_1_3: lat=%0d q=%h r=%h s=%b, required lat=%0d q=555_5555 r=1 s=%b",
               lat, quotient, remainder, sticky, LAT, exp_sticky(28'd1));
    end
  endtask

  task automatic test_div_zero();
    int lat; bit fb, bs;
    run_op(28'd5, 28'd0, -1, lat, fb, bs);
    tests_run++;
    if (lat !== 1 || fb !== 1'b0 || bs !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbz_timing: lat=%0d first_busy=%b busy_seen=%b busy=%b, required 1 0 0 0", lat, fb, bs, busy);
    end
    tests_run++;
    if (div_by_zero !== 1'b1 || quotient !== {QW{1'b1}} || remainder !== 28'd5 || sticky !== exp_sticky(28'd5)) begin
      tests_failed++;
      $display("FAIL dbz_5_0: dbz=%b q=%h r=%h s=%b, required 1 all-ones 5 %b",
               div_by_zero, quotient, remainder, sticky, exp_sticky(28'd5));
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit fb, bs;
    run_op(28'd3, 28'd2, 10, lat, fb, bs);
    tests_run++;
    if (lat !== LAT || quotient !== 56'h1800_0000 || remainder !== '0) begin
      tests_failed++;
      $display("FAIL busy_ignore: lat=%0d q=%h r=%h, required lat=%0d q=1800_0000 r=0", lat, quotient, remainder, LAT);
    end
    // Start issued in the DONE cycle of the previous operation.
    run_op(28'd1, 28'd3, -1, lat, fb, bs);
    tests_run++;
    if (lat !== LAT || quotient !== 56'h555_5555 || remainder !== 28'd1) begin
      tests_failed++;
      $display("FAIL back_to_back: lat=%0d q=%h r=%h, required lat=%0d q=555_5555 r=1", lat, quotient, remainder, LAT);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, ndone; bit fb, bs;
    dividend = 28'd1;
    divisor  = 28'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if ({busy, done, quotient, remainder, sticky, div_by_zero} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: busy=%b done=%b q=%h r=%h s=%b dbz=%b, required all 0",
               busy, done, quotient, remainder, sticky, div_by_zero);
    end
    ndone = 0;
    repeat (70) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (ndone !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: done pulses=%0d, required 0", ndone);
    end
    run_op(28'hFF_FFFF, 28'hFF_FFFF, -1, lat, fb, bs);
    tests_run++;
    if (lat !== LAT || quotient !== 56'h1000_0000 || remainder !== '0 || sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_op: lat=%0d q=%h r=%h s=%b, required lat=%0d q=1000_0000 r=0 s=0",
               lat, quotient, remainder, sticky, LAT);
    end
  endtask

  task automatic test_random();
    int lat; bit fb, bs;
    logic [W-1:0] a, b;
    longint unsigned num;
    logic [QW-1:0] eq;
    logic [W-1:0] er;
    logic edbz;
    int elat;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = W'($urandom_range(1, 255));
        2: b = {1'b1, W'($urandom) >> 1};
        default: b = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: a = '0;
        1: a = {1'b1, W'($urandom) >> 1};
        default: a = W'($urandom);
      endcase
      if (b == '0) begin
        eq = '1; er = a; edbz = 1'b1; elat = 1;
      end else begin
        num  = longint'(a) << F;
        eq   = QW'(num / longint'(b));
        er   = W'(num % longint'(b));
        edbz = 1'b0;
        elat = LAT;
      end
      run_op(a, b, -1, lat, fb, bs);
      tests_run++;
      if (lat !== elat || quotient !== eq || remainder !== er || sticky !== exp_sticky(er) ||
          div_by_zero !== edbz || bs !== !edbz) begin
        tests_failed++;
        $display("FAIL random a=%h b=%h: lat=%0d q=%h r=%h s=%b dbz=%b busy_seen=%b, required lat=%0d q=%h r=%h s=%b dbz=%b busy_seen=%b",
                 a, b, lat, quotient, remainder, sticky, div_by_zero, bs,
                 elat, eq, er, exp_sticky(er), edbz, !edbz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_quotient();
    test_sticky();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
